ecc_51_err_collect: RTL and testbench

- Downstream stage of the 51-bit ECC fault-detect block on the FIFO read path.
- Accepts the corrected read word plus per-word sbit_err/dbit_err/ecc_fault flags and forwards the word through a 1-entry valid/ready pipeline register.
- Keeps saturating error counters, captures the first error's address and type, tracks overflow with a 3-state FSM, and raises a sticky interrupt until software clears it.

---
 rtl/ecc_51_err_collect.sv | 152 +++++++++++++++
 tb/tb_ecc_51_err_collect.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_51_err_collect.sv
// Error collector behind the 51-bit ECC check: 1-entry valid/ready stage plus error status.
// Optional macro ECC_ERR_TS_EN adds a free-running timestamp and the first_err_ts output.
module ecc_51_err_collect #(
    parameter int unsigned DATA_WIDTH      = 51,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned SBIT_IRQ_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic                  in_ecc_fault,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_poison,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [1:0]            first_err_type,
    output logic                  err_ovf,
    output logic                  irq
`ifdef ECC_ERR_TS_EN
    ,
    output logic [31:0]           first_err_ts
`endif
);

    typedef enum logic [1:0] {
        StNoErr    = 2'd0,
        StOneErr   = 2'd1,
        StMultiErr = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] SbitThresh = CNT_WIDTH'(SBIT_IRQ_THRESH);

    state_e                  state_q, state_b, state_d;
    logic                    accept, err_beat, capture;
    logic [1:0]              err_type;
    logic [CNT_WIDTH-1:0]    sbit_cnt_d, dbit_cnt_d, fault_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_d;
    logic [1:0]              first_err_type_d;
    logic                    irq_d;

    assign in_rdy   = ~out_vld | out_rdy;
    assign accept   = in_vld & in_rdy;
    assign err_beat = accept & (in_sbit_err | in_dbit_err | in_ecc_fault);
    assign err_type = in_ecc_fault ? 2'd3 : (in_dbit_err ? 2'd2 : 2'd1);
    assign err_ovf  = (state_q == StMultiErr);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_poison <= 1'b0;
        end else if (accept) begin
            out_vld    <= 1'b1;
            out_data   <= in_data;
            out_poison <= in_dbit_err | in_ecc_fault;
        end else if (out_vld && out_rdy) begin
            out_vld    <= 1'b0;
        end
    end

    // clr yields a zeroed base state; a same-cycle error beat is then applied on top of it
    always_comb begin
        sbit_cnt_d       = clr ? '0 : sbit_cnt;
        dbit_cnt_d       = clr ? '0 : dbit_cnt;
        fault_cnt_d      = clr ? '0 : fault_cnt;
        first_err_addr_d = clr ? '0 : first_err_addr;
        first_err_type_d = clr ? 2'd0 : first_err_type;
        irq_d            = clr ? 1'b0 : irq;
        state_b          = clr ? StNoErr : state_q;
        state_d          = state_b;
        capture          = 1'b0;

        if (accept && in_sbit_err && sbit_cnt_d != '1) begin
            sbit_cnt_d = sbit_cnt_d + CNT_WIDTH'(1);
        end
        if (accept && in_dbit_err && dbit_cnt_d != '1) begin
            dbit_cnt_d = dbit_cnt_d + CNT_WIDTH'(1);
        end
        if (accept && in_ecc_fault && fault_cnt_d != '1) begin
            fault_cnt_d = fault_cnt_d + CNT_WIDTH'(1);
        end

        case (state_b)
            StNoErr: begin
                if (err_beat) begin
                    state_d = StOneErr;
                    capture = 1'b1;
                end
            end
            StOneErr: begin
                if (err_beat) state_d = StMultiErr;
            end
            StMultiErr: state_d = StMultiErr;
            default:    state_d = StNoErr;
        endcase

        if (capture) begin
            first_err_addr_d = in_addr;
            first_err_type_d = err_type;
        end

        if (accept && (in_dbit_err || in_ecc_fault)) irq_d = 1'b1;
        if (sbit_cnt_d == SbitThresh) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StNoErr;
            sbit_cnt       <= '0;
            dbit_cnt       <= '0;
            fault_cnt      <= '0;
            first_err_addr <= '0;
            first_err_type <= 2'd0;
            irq            <= 1'b0;
        end else begin
            state_q        <= state_d;
            sbit_cnt       <= sbit_cnt_d;
            dbit_cnt       <= dbit_cnt_d;
            fault_cnt      <= fault_cnt_d;
            first_err_addr <= first_err_addr_d;
            first_err_type <= first_err_type_d;
            irq            <= irq_d;
        end
    end

`ifdef ECC_ERR_TS_EN
    logic [31:0] ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts           <= '0;
            first_err_ts <= '0;
        end else begin
            ts <= ts + 32'd1;
            if (capture) first_err_ts <= ts;
            else if (clr) first_err_ts <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_51_err_collect.sv
// Directed bench for ecc_51_err_collect; checks the ECC_ERR_TS_EN timestamp when the macro is set.
module tb_ecc_51_err_collect;

    logic        clk = 1'b0;
    logic        rst, in_vld, in_rdy, in_sbit_err, in_dbit_err, in_ecc_fault;
    logic [7:0]  in_addr;
    logic [50:0] in_data, out_data;
    logic        out_vld, out_rdy, out_poison, clr, err_ovf, irq;
    logic [15:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic [7:0]  first_err_addr;
    logic [1:0]  first_err_type;
`ifdef ECC_ERR_TS_EN
    logic [31:0] first_err_ts;
    logic [31:0] ts_m;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    logic [50:0] exp_data [4];

    always #5 clk = ~clk;

    ecc_51_err_collect dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_sbit_err    (in_sbit_err),
        .in_dbit_err    (in_dbit_err),
        .in_ecc_fault   (in_ecc_fault),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_data       (out_data),
        .out_poison     (out_poison),
        .clr            (clr),
        .sbit_cnt       (sbit_cnt),
        .dbit_cnt       (dbit_cnt),
        .fault_cnt      (fault_cnt),
        .first_err_addr (first_err_addr),
        .first_err_type (first_err_type),
        .err_ovf        (err_ovf),
        .irq            (irq)
`ifdef ECC_ERR_TS_EN
        ,
        .first_err_ts   (first_err_ts)
`endif
    );

`ifdef ECC_ERR_TS_EN
    always @(posedge clk) ts_m <= rst ? 32'd0 : ts_m + 32'd1;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [7:0] a, input logic [50:0] d,
                            input logic s, input logic db, input logic f);
        in_vld       = v;
        in_addr      = a;
        in_data      = d;
        in_sbit_err  = s;
        in_dbit_err  = db;
        in_ecc_fault = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        out_rdy = 1'b1;
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_eq("rst_out_vld", out_vld, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_poison", out_poison, 0);
        check_eq("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        check_eq("rst_capture", {first_err_addr, first_err_type}, 0);
        check_eq("rst_ovf_irq", {err_ovf, irq}, 0);
`ifdef ECC_ERR_TS_EN
        check_eq("rst_ts", first_err_ts, 0);
`endif
        rst = 1'b0;

        // Four clean beats, back to back.
        exp_data[0] = 51'h1_2345_6789_ABCD;
        exp_data[1] = 51'h7_FFFF_FFFF_FFFF;
        exp_data[2] = 51'h0_0000_0000_0001;
        exp_data[3] = 51'h5_5555_AAAA_5555;
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, 8'(i), exp_data[i], 1'b0, 1'b0, 1'b0);
            step();
            check_eq($sformatf("clean_data%0d", i), out_data, exp_data[i]);
            check_eq($sformatf("clean_vld%0d", i), out_vld, 1);
        end
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("clean_drain", out_vld, 0);
        check_eq("clean_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        check_eq("clean_irq_type", {irq, first_err_type}, 0);

`ifdef ECC_ERR_TS_EN
        while (ts_m < 32'd100) step();
        set_beat(1'b1, 8'h05, 51'h11, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("ts_capture", first_err_ts, 100);
        step();
        check_eq("ts_hold", first_err_ts, 100);
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("ts_clr", first_err_ts, 0);
        check_eq("ts_clr_cnt", sbit_cnt, 0);
`endif

        // sbit beat then dbit beat.
        set_beat(1'b1, 8'h12, 51'hAAA, 1'b1, 1'b0, 1'b0);
        step();
        check_eq("sb_poison", out_poison, 0);
        check_eq("sb_irq", irq, 0);
        check_eq("sb_capture", {first_err_addr, first_err_type}, {8'h12, 2'd1});
        check_eq("sb_ovf", err_ovf, 0);
        set_beat(1'b1, 8'h34, 51'hBBB, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("db_poison", out_poison, 1);
        check_eq("db_irq", irq, 1);
        check_eq("db_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, {16'd1, 16'd1, 16'd0});
        check_eq("db_capture", {first_err_addr, first_err_type}, {8'h12, 2'd1});
        check_eq("db_ovf", err_ovf, 1);
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        step();

        // Backpressure: stalled beat carries sbit so a wrongful accept would count.
        set_beat(1'b1, 8'h40, 51'hA0A0, 1'b0, 1'b0, 1'b0);
        step();
        out_rdy = 1'b0;
        set_beat(1'b1, 8'h41, 51'hB0B0, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("stall_in_rdy", in_rdy, 0);
        for (int i = 0; i < 5; i++) step();
        check_eq("stall_data", out_data, 51'hA0A0);
        check_eq("stall_vld", out_vld, 1);
        check_eq("stall_cnt", sbit_cnt, 1);
        out_rdy = 1'b1;
        step();
        check_eq("release_data", out_data, 51'hB0B0);
        check_eq("release_cnt", sbit_cnt, 2);
        set_beat(1'b1, 8'h42, 51'hC0C0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("release_next", out_data, 51'hC0C0);
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("release_drain", out_vld, 0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        check_eq("clr_status", {first_err_addr, first_err_type, err_ovf, irq}, 0);

        // sbit threshold then saturation.
        set_beat(1'b1, 8'h20, 51'h1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        check_eq("thr15_cnt", sbit_cnt, 15);
        check_eq("thr15_irq", irq, 0);
        step();
        check_eq("thr16_cnt", sbit_cnt, 16);
        check_eq("thr16_irq", irq, 1);
        for (int i = 0; i < 65536 + 5 - 16; i++) step();
        check_eq("sat_cnt", sbit_cnt, 16'hFFFF);
        check_eq("sat_irq", irq, 1);
        check_eq("sat_dbit", dbit_cnt, 0);

        // clr together with an accepted fault beat.
        clr = 1'b1;
        set_beat(1'b1, 8'h07, 51'h77, 1'b0, 1'b0, 1'b1);
        step();
        clr = 1'b0;
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        check_eq("clrf_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, {16'd0, 16'd0, 16'd1});
        check_eq("clrf_capture", {first_err_addr, first_err_type}, {8'h07, 2'd3});
        check_eq("clrf_ovf_irq", {err_ovf, irq}, 2'b01);
        check_eq("clrf_pipe", {out_vld, out_poison, out_data}, {2'b11, 51'h77});

        // rst drops a held beat.
        out_rdy = 1'b0;
        set_beat(1'b1, 8'h08, 51'h88, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("hold_vld", out_vld, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_beat(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_drop_vld", out_vld, 0);
        check_eq("rst_drop_irq", irq, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
